// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a dual-clock FIFO: write-pointer synchroniser, read pointers, level and flags.
// Optional sticky underflow detection is enabled by defining FIFO_RD_UNDERFLOW_EN.
module fifo_rd_ctrl #(
  parameter int unsigned ADDRSIZE    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                i_rd_clk,
  input  logic                i_rd_rst,
  input  logic                i_rd_en,
  input  logic [ADDRSIZE:0]   i_wr_ptr,
  input  logic [ADDRSIZE:0]   i_ae_thresh,
  input  logic                i_uf_clr,
  output logic [ADDRSIZE-1:0] o_rd_addr,
  output logic [ADDRSIZE:0]   o_rd_ptr,
  output logic                o_empty,
  output logic                o_almost_empty,
  output logic [ADDRSIZE:0]   o_rd_level,
  output logic                o_rd_valid,
  output logic                o_underflow
);

  logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
  logic [ADDRSIZE:0] wr_gray_s;
  logic [ADDRSIZE:0] wr_bin_s;

  logic [ADDRSIZE:0] rd_bin_q,  rd_bin_d;
  logic [ADDRSIZE:0] rd_gray_q, rd_gray_d;
  logic [ADDRSIZE:0] level_q,   level_d;
  logic              empty_q,   empty_d;
  logic              ae_q,      ae_d;
  logic              valid_q,   valid_d;
  logic              uf_q,      uf_d;
  logic              rd_fire;

  assign wr_gray_s = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wr_bin_s = '0;
    for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
      wr_bin_s[i] = ^(wr_gray_s >> i);
    end
  end

  assign rd_fire = i_rd_en & ~empty_q;

  always_comb begin
    rd_bin_d  = rd_bin_q + {{ADDRSIZE{1'b0}}, rd_fire};
    rd_gray_d = (rd_bin_d >> 1) ^ rd_bin_d;
    level_d   = wr_bin_s - rd_bin_d;
    empty_d   = (rd_gray_d == wr_gray_s);
    ae_d      = (level_d <= i_ae_thresh);
    valid_d   = rd_fire;
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  // Set has priority over clear so a simultaneous error is never lost.
  always_comb begin
    uf_d = uf_q;
    if (i_uf_clr)           uf_d = 1'b0;
    if (i_rd_en && empty_q) uf_d = 1'b1;
  end
`else
  logic unused_uf_clr;
  assign unused_uf_clr = i_uf_clr;
  always_comb begin
    uf_d = 1'b0;
  end
`endif

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      ae_q      <= 1'b1;
      valid_q   <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      sync_q[0] <= i_wr_ptr;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      level_q   <= level_d;
      empty_q   <= empty_d;
      ae_q      <= ae_d;
      valid_q   <= valid_d;
      uf_q      <= uf_d;
    end
  end

  assign o_rd_addr      = rd_bin_q[ADDRSIZE-1:0];
  assign o_rd_ptr       = rd_gray_q;
  assign o_empty        = empty_q;
  assign o_almost_empty = ae_q;
  assign o_rd_level     = level_q;
  assign o_rd_valid     = valid_q;
  assign o_underflow    = uf_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl (ADDRSIZE=4, SYNC_STAGES=2).
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en;
  logic [4:0] wr_ptr;
  logic [4:0] ae_thresh;
  logic       uf_clr;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr;
  logic       empty;
  logic       almost_empty;
  logic [4:0] rd_level;
  logic       rd_valid;
  logic       underflow;

  int total = 0;
  int bad   = 0;

`ifdef FIFO_RD_UNDERFLOW_EN
  localparam logic UF_ON = 1'b1;
`else
  localparam logic UF_ON = 1'b0;
`endif

  fifo_rd_ctrl #(.ADDRSIZE(4), .SYNC_STAGES(2)) dut (
    .i_rd_clk      (clk),
    .i_rd_rst      (rst),
    .i_rd_en       (rd_en),
    .i_wr_ptr      (wr_ptr),
    .i_ae_thresh   (ae_thresh),
    .i_uf_clr      (uf_clr),
    .o_rd_addr     (rd_addr),
    .o_rd_ptr      (rd_ptr),
    .o_empty       (empty),
    .o_almost_empty(almost_empty),
    .o_rd_level    (rd_level),
    .o_rd_valid    (rd_valid),
    .o_underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_en = 1'b0; uf_clr = 1'b0; wr_ptr = 5'd0; ae_thresh = 5'd2;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({empty, almost_empty, rd_level, rd_valid, underflow, rd_ptr, rd_addr} !==
        {1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0}) begin
      bad++;
      $display("FAIL reset_state: got e=%b ae=%b lvl=%0d v=%b uf=%b ptr=%b addr=%0d want e=1 ae=1 lvl=0 v=0 uf=0 ptr=0 addr=0",
               empty, almost_empty, rd_level, rd_valid, underflow, rd_ptr, rd_addr);
    end
  endtask

  task automatic test_empty_read();
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({empty, rd_level, rd_valid, rd_addr, underflow} !== {1'b1, 5'd0, 1'b0, 4'd0, UF_ON}) begin
        bad++;
        $display("FAIL empty_read[%0d]: got e=%b lvl=%0d v=%b addr=%0d uf=%b want e=1 lvl=0 v=0 addr=0 uf=%b",
                 i, empty, rd_level, rd_valid, rd_addr, underflow, UF_ON);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_fill_and_read();
    do_reset();
    wr_ptr = 5'b00010;
    tick(); tick();
    total++;
    if (empty !== 1'b1) begin
      bad++; $display("FAIL sync_latency: empty got %b want 1", empty);
    end
    tick();
    total++;
    if ({empty, rd_level, almost_empty} !== {1'b0, 5'd3, 1'b0}) begin
      bad++;
      $display("FAIL fill3: got e=%b lvl=%0d ae=%b want e=0 lvl=3 ae=0", empty, rd_level, almost_empty);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++;
    if ({rd_valid, rd_level, almost_empty, rd_addr, rd_ptr} !== {1'b1, 5'd2, 1'b1, 4'd1, 5'b00001}) begin
      bad++;
      $display("FAIL single_read: got v=%b lvl=%0d ae=%b addr=%0d ptr=%b want v=1 lvl=2 ae=1 addr=1 ptr=00001",
               rd_valid, rd_level, almost_empty, rd_addr, rd_ptr);
    end
    tick();
    total++;
    if (rd_valid !== 1'b0) begin
      bad++; $display("FAIL valid_pulse: got %b want 0", rd_valid);
    end
  endtask

  // Continues from test_fill_and_read: rd=1, wr=3 synced.
  task automatic test_read_with_write();
    wr_ptr = 5'b00111;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++;
    if ({rd_level, empty} !== {5'd1, 1'b0}) begin
      bad++; $display("FAIL rw_stage1: got lvl=%0d e=%b want lvl=1 e=0", rd_level, empty);
    end
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++;
    if ({rd_level, rd_valid, rd_addr, almost_empty} !== {5'd2, 1'b1, 4'd3, 1'b1}) begin
      bad++;
      $display("FAIL rw_same_cycle: got lvl=%0d v=%b addr=%0d ae=%b want lvl=2 v=1 addr=3 ae=1",
               rd_level, rd_valid, rd_addr, almost_empty);
    end
    ae_thresh = 5'd1;
    tick();
    total++;
    if (almost_empty !== 1'b0) begin
      bad++; $display("FAIL ae_thresh_change: got %b want 0", almost_empty);
    end
  endtask

  task automatic test_full_drain();
    do_reset();
    wr_ptr = 5'b11000;
    tick(); tick(); tick();
    total++;
    if ({rd_level, empty, almost_empty} !== {5'b10000, 1'b0, 1'b0}) begin
      bad++; $display("FAIL full_level: got lvl=%b e=%b ae=%b want lvl=10000 e=0 ae=0", rd_level, empty, almost_empty);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rd_addr !== 4'(i)) begin
        bad++; $display("FAIL drain_addr[%0d]: got %0d want %0d", i, rd_addr, i);
      end
      tick();
    end
    rd_en = 1'b0;
    total++;
    if ({empty, rd_ptr, rd_level, rd_valid} !== {1'b1, 5'b11000, 5'd0, 1'b1}) begin
      bad++;
      $display("FAIL drain_end: got e=%b ptr=%b lvl=%0d v=%b want e=1 ptr=11000 lvl=0 v=1",
               empty, rd_ptr, rd_level, rd_valid);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_addr;
    do_reset();
    wr_ptr = 5'b01001;
    tick(); tick(); tick();
    rd_en = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    rd_en = 1'b0;
    total++;
    if ({empty, rd_level, rd_addr} !== {1'b1, 5'd0, 4'd14}) begin
      bad++; $display("FAIL wrap_setup: got e=%b lvl=%0d addr=%0d want e=1 lvl=0 addr=14", empty, rd_level, rd_addr);
    end
    wr_ptr = 5'b11011;
    tick(); tick(); tick();
    total++;
    if ({empty, rd_level} !== {1'b0, 5'd4}) begin
      bad++; $display("FAIL wrap_level: got e=%b lvl=%0d want e=0 lvl=4", empty, rd_level);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr = 4'(14 + i);
      total++;
      if (rd_addr !== exp_addr) begin
        bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, rd_addr, exp_addr);
      end
      tick();
    end
    rd_en = 1'b0;
    total++;
    if ({empty, rd_ptr, rd_level} !== {1'b1, 5'b11011, 5'd0}) begin
      bad++; $display("FAIL wrap_end: got e=%b ptr=%b lvl=%0d want e=1 ptr=11011 lvl=0", empty, rd_ptr, rd_level);
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    wr_ptr = 5'b00110;
    tick(); tick(); tick();
    rd_en = 1'b1;
    tick();
    rst = 1'b1;
    wr_ptr = 5'd0;
    tick();
    rst = 1'b0;
    rd_en = 1'b0;
    total++;
    if ({empty, almost_empty, rd_level, rd_valid, underflow, rd_ptr, rd_addr} !==
        {1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0}) begin
      bad++;
      $display("FAIL reset_midburst: got e=%b ae=%b lvl=%0d v=%b uf=%b ptr=%b addr=%0d want 1 1 0 0 0 0 0",
               empty, almost_empty, rd_level, rd_valid, underflow, rd_ptr, rd_addr);
    end
  endtask

  task automatic test_underflow_clear();
    do_reset();
    rd_en = 1'b1;
    tick();
    uf_clr = 1'b1;
    tick();
    total++;
    if (underflow !== UF_ON) begin
      bad++; $display("FAIL uf_set_wins: got %b want %b", underflow, UF_ON);
    end
    rd_en = 1'b0;
    tick();
    uf_clr = 1'b0;
    total++;
    if (underflow !== 1'b0) begin
      bad++; $display("FAIL uf_clear: got %b want 0", underflow);
    end
  endtask

  initial begin
    test_reset();
    test_empty_read();
    test_fill_and_read();
    test_read_with_write();
    test_full_drain();
    test_wrap();
    test_reset_midburst();
    test_underflow_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
